astro_rom_loader: RTL
=====================

Name: astro_rom_loader

Overview:
- Sits between the HPS download port (16-bit word stream, byte addresses, wait handshake) and the 8 KB, 8-bit-wide BIOS and cart dpram images in the Astrocade core.
- Splits each word into two sequenced byte writes and throttles the HPS with a wait signal.
- Steers writes by download index, tracks the loaded cart size, and derives a power-of-two address mask for cart mirroring.

Parameters:
- ADDR_W, 13, byte address width of each ROM image (8192 bytes).
- SIZE_W, 14, width of the cart size counter; must hold 2^ADDR_W.

Ports:
- CLK  in  1  system clock; all logic is single-clock.
- I_RESET_L  in  1  asynchronous, active-low reset.
- I_DL  in  1  download active (level).
- I_DL_INDEX  in  8  download target: 0 = BIOS, 1 = cart, any other value is discarded.
- I_DL_WR  in  1  one-cycle word write strobe.
- I_DL_ADDR  in  25  byte address of the word.
- I_DL_DATA  in  16  word data, little-endian.
- O_DL_WAIT  out  1  stall request back to the HPS.
- O_MEM_ADDR  out  ADDR_W  shared byte address to both dprams.
- O_MEM_DATA  out  8  byte data.
- O_BIOS_WE  out  1  BIOS dpram write enable.
- O_CART_WE  out  1  cart dpram write enable.
- O_CART_SIZE  out  SIZE_W  bytes loaded; saturates at 8192.
- O_CART_MASK  out  ADDR_W  cart address mask.
- O_BUSY  out  1  high when the FSM is not in IDLE.
- O_DONE  out  1  one-cycle pulse at the end of a download.

Behaviour:
- Reset values: all outputs 0 and FSM in IDLE. O_CART_MASK resets to 13'h1FFF.
- FSM states: IDLE, WR_LO, WR_HI, FILL (FILL exists only with the optional feature).
- IDLE:
  - I_DL rising edge with index 1: clear the size register.
  - I_DL_WR with I_DL=1: latch {index, addr with bit0 forced to 0, data}, go to WR_LO.
- WR_LO (1 cycle):
  - O_MEM_ADDR = addr[12:0], O_MEM_DATA = data[7:0].
  - WE asserted on the target selected by index.
  - O_DL_WAIT = 1.
- WR_HI (1 cycle):
  - O_MEM_ADDR = addr[12:0]|1, O_MEM_DATA = data[15:8], WE on the target.
  - O_DL_WAIT = 1. Return to IDLE.
- Latency: strobe at cycle t gives the low-byte write at t+1 and the high-byte write at t+2. The next strobe is accepted at t+3; one word per 3 cycles maximum.
- Writes with addr >= 8192 or index not in {0,1}:
  - No WE is asserted.
  - The same WR_LO/WR_HI timing and wait handshake still run.
- Cart size update: on every cart word, size <= max(size, addr+2), saturated at 8192. This includes words dropped because addr >= 8192.
- I_DL_WR arriving in any non-IDLE state is a protocol violation. The strobe is ignored and no state changes.
- I_DL falling edge:
  - If a WR_LO/WR_HI sequence is in flight, it completes first.
  - The end-of-download action is deferred until the FSM returns to IDLE.
- End of a cart download:
  - O_CART_MASK <= (smallest power of two >= size, minimum 2048) - 1. Sizes 0 and 1 both give 2047.
  - O_DONE pulses one cycle after the return to IDLE, or after FILL completes when the optional feature is compiled in.
- End of a BIOS download: O_DONE pulses; size and mask are unchanged.
- I_RESET_L asserted mid-download: immediate return to IDLE, all outputs at their reset values. Partial dpram contents are left as written.

Optional Feature:
- Macro: ASTRO_CART_FILL_EN.
- With the macro:
  - After a cart download whose size < 8192, enter FILL.
  - FILL writes 8'hFF to cart addresses size..8191 at one byte per cycle, with O_CART_WE=1.
  - O_BUSY stays 1 throughout FILL. O_DL_WAIT stays 0 because the download is already over.
  - O_DONE pulses after the write to 8191.
  - A new I_DL rising edge during FILL aborts FILL and goes to IDLE; no O_DONE pulse.
- Without the macro: no FILL state. Stale bytes above size remain in the dpram.

Decomposition:
- Package astro_loader_pkg holds:
  - the state enum;
  - ROM_BYTES=8192, FILL_BYTE=8'hFF, MIN_MASK=13'h07FF;
  - IDX_BIOS=8'd0, IDX_CART=8'd1.
- One sub-module, astro_size_to_mask: combinational size-to-power-of-two-mask function, kept separate for unit testing.

Test Plan:
- BIOS word 16'hA55A at addr 0x0010 -> BIOS WE at 0x0010 with 0x5A, then at 0x0011 with 0xA5. O_DL_WAIT high exactly 2 cycles. Cart WE never asserted.
- Cart download of 2048 bytes (1024 words), then I_DL falls -> O_CART_SIZE=2048, O_CART_MASK=0x07FF, one O_DONE pulse.
- Cart download of 4098 bytes -> size=4098, mask=0x1FFF. Repeat with 4096 bytes -> mask=0x0FFF.
- Cart word at addr 0x2000 -> no WE, wait still 2 cycles, size saturates at 8192. Word with index 3 -> no WE on either image.
- Reset asserted during WR_HI -> WE and wait drop immediately, FSM in IDLE, mask=0x1FFF.
- ASTRO_CART_FILL_EN with a 100-byte cart -> 8092 writes of 0xFF covering addresses 100..8191, O_BUSY held high, O_DONE pulses once after the write to 8191.

Source files
------------

// File: rtl/astro_loader_pkg.sv
// Shared types and constants for the Astrocade ROM loader.
//   state_t   : loader FSM states (FILL only with ASTRO_CART_FILL_EN)
//   ROM_BYTES : size of each dpram image in bytes
//   FILL_BYTE : value written above the loaded cart size when filling
//   MIN_MASK  : smallest cart mirror mask (2 KB cart)
//   IDX_*     : HPS download index values that select an image
package astro_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_LO,
        WR_HI
`ifdef ASTRO_CART_FILL_EN
        , FILL
`endif
    } state_t;

    localparam int          ROM_BYTES = 8192;
    localparam logic [7:0]  FILL_BYTE = 8'hFF;
    localparam logic [12:0] MIN_MASK  = 13'h07FF;
    localparam logic [7:0]  IDX_BIOS  = 8'd0;
    localparam logic [7:0]  IDX_CART  = 8'd1;

endpackage

// File: rtl/astro_size_to_mask.sv
// Combinational cart size to mirror mask.
//   size : bytes loaded (0 .. 2^ADDR_W)
//   mask : (smallest power of two >= size, at least 2 KB) - 1
module astro_size_to_mask
    import astro_loader_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int SIZE_W = 14
) (
    input  logic [SIZE_W-1:0] size,
    output logic [ADDR_W-1:0] mask
);

    localparam logic [SIZE_W:0] ONE = 1;

    logic [SIZE_W:0] span;

    // Grow the mask one bit at a time until the covered span reaches size.
    // Once the mask is all ones further shifts leave it unchanged.
    always_comb begin
        mask = ADDR_W'(MIN_MASK);
        span = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            span = (SIZE_W+1)'(mask) + ONE;
            if (span < {1'b0, size})
                mask = {mask[ADDR_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/astro_rom_loader.sv
// HPS download to BIOS/cart dpram loader for the Astrocade core.
// Each 16-bit word is written as two bytes (low then high) on consecutive
// cycles while O_DL_WAIT stalls the HPS. Cart downloads track the loaded
// size and publish a power-of-two mirror mask when the download ends.
//   CLK, I_RESET_L          : clock, async active-low reset
//   I_DL, I_DL_INDEX        : download active / target (0 BIOS, 1 cart)
//   I_DL_WR, I_DL_ADDR/DATA : word strobe, byte address, little-endian word
//   O_DL_WAIT               : stall back to the HPS
//   O_MEM_ADDR/DATA, O_*_WE : shared byte write port to both dprams
//   O_CART_SIZE/MASK        : loaded cart bytes and mirror mask
//   O_BUSY, O_DONE          : FSM not idle / end-of-download pulse
// Optional: define ASTRO_CART_FILL_EN to pad the cart image above the loaded
// size with 8'hFF after each short cart download.
module astro_rom_loader
    import astro_loader_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int SIZE_W = 14
) (
    input  logic              CLK,
    input  logic              I_RESET_L,
    input  logic              I_DL,
    input  logic [7:0]        I_DL_INDEX,
    input  logic              I_DL_WR,
    input  logic [24:0]       I_DL_ADDR,
    input  logic [15:0]       I_DL_DATA,
    output logic              O_DL_WAIT,
    output logic [ADDR_W-1:0] O_MEM_ADDR,
    output logic [7:0]        O_MEM_DATA,
    output logic              O_BIOS_WE,
    output logic              O_CART_WE,
    output logic [SIZE_W-1:0] O_CART_SIZE,
    output logic [ADDR_W-1:0] O_CART_MASK,
    output logic              O_BUSY,
    output logic              O_DONE
);

    localparam logic [SIZE_W-1:0] ROM_SIZE = SIZE_W'(ROM_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state;
    logic              dl_q;
    logic [7:0]        dl_idx;      // index of the download in progress
    logic              end_pend;    // I_DL fell while a word was in flight
    logic [7:0]        hi_data;

    logic              dl_rise, dl_fall, in_range;
    logic [25:0]       word_end;
    logic [SIZE_W-1:0] size_sat, size_base, size_upd;
    logic [ADDR_W-1:0] mask_next;
    logic              unused_addr_lsb;

    assign dl_rise  = I_DL & ~dl_q;
    assign dl_fall  = dl_q & ~I_DL;
    assign in_range = (I_DL_ADDR[24:ADDR_W] == '0);

    // Word always occupies an even byte address; size grows to its end,
    // including dropped out-of-range words, and saturates at the image size.
    assign word_end  = {1'b0, I_DL_ADDR[24:1], 1'b0} + 26'd2;
    assign size_sat  = (word_end >= 26'(ROM_BYTES)) ? ROM_SIZE : word_end[SIZE_W-1:0];
    assign size_base = dl_rise ? '0 : O_CART_SIZE;
    assign size_upd  = (size_sat > size_base) ? size_sat : size_base;

    assign unused_addr_lsb = I_DL_ADDR[0];

    assign O_BUSY = (state != IDLE);

    astro_size_to_mask #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) u_mask (
        .size (O_CART_SIZE),
        .mask (mask_next)
    );

    always_ff @(posedge CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state       <= IDLE;
            dl_q        <= 1'b0;
            dl_idx      <= '0;
            end_pend    <= 1'b0;
            hi_data     <= '0;
            O_DL_WAIT   <= 1'b0;
            O_MEM_ADDR  <= '0;
            O_MEM_DATA  <= '0;
            O_BIOS_WE   <= 1'b0;
            O_CART_WE   <= 1'b0;
            O_CART_SIZE <= '0;
            O_CART_MASK <= '1;
            O_DONE      <= 1'b0;
        end else begin
            dl_q   <= I_DL;
            O_DONE <= 1'b0;
            if (I_DL)
                dl_idx <= I_DL_INDEX;
            if (dl_fall)
                end_pend <= 1'b1;
            if (dl_rise && I_DL_INDEX == IDX_CART)
                O_CART_SIZE <= '0;

            case (state)
                IDLE: begin
                    if (end_pend || dl_fall) begin
                        end_pend <= 1'b0;
                        if (dl_idx == IDX_CART) begin
                            O_CART_MASK <= mask_next;
`ifdef ASTRO_CART_FILL_EN
                            if (O_CART_SIZE < ROM_SIZE) begin
                                state      <= FILL;
                                O_MEM_ADDR <= O_CART_SIZE[ADDR_W-1:0];
                                O_MEM_DATA <= FILL_BYTE;
                                O_CART_WE  <= 1'b1;
                            end else begin
                                O_DONE <= 1'b1;
                            end
`else
                            O_DONE <= 1'b1;
`endif
                        end else if (dl_idx == IDX_BIOS) begin
                            O_DONE <= 1'b1;
                        end
                    end else if (I_DL_WR && I_DL) begin
                        state      <= WR_LO;
                        O_MEM_ADDR <= {I_DL_ADDR[ADDR_W-1:1], 1'b0};
                        O_MEM_DATA <= I_DL_DATA[7:0];
                        hi_data    <= I_DL_DATA[15:8];
                        O_BIOS_WE  <= in_range && (I_DL_INDEX == IDX_BIOS);
                        O_CART_WE  <= in_range && (I_DL_INDEX == IDX_CART);
                        O_DL_WAIT  <= 1'b1;
                        if (I_DL_INDEX == IDX_CART)
                            O_CART_SIZE <= size_upd;
                    end
                end
                // Write enables carry over from the low byte to the high byte.
                WR_LO: begin
                    state      <= WR_HI;
                    O_MEM_ADDR <= O_MEM_ADDR | ADDR_ONE;
                    O_MEM_DATA <= hi_data;
                end
                WR_HI: begin
                    state      <= IDLE;
                    O_MEM_ADDR <= '0;
                    O_MEM_DATA <= '0;
                    O_BIOS_WE  <= 1'b0;
                    O_CART_WE  <= 1'b0;
                    O_DL_WAIT  <= 1'b0;
                end
`ifdef ASTRO_CART_FILL_EN
                // O_MEM_ADDR doubles as the fill pointer.
                FILL: begin
                    if (dl_rise || O_MEM_ADDR == '1) begin
                        state      <= IDLE;
                        O_MEM_ADDR <= '0;
                        O_MEM_DATA <= '0;
                        O_CART_WE  <= 1'b0;
                        O_DONE     <= !dl_rise;
                    end else begin
                        O_MEM_ADDR <= O_MEM_ADDR + ADDR_ONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
